// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing the user_io SD sector port between two clients.
// Buffer traffic follows the grant; a watchdog gives up on a missing sd_ack.
module sd_req_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 4_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req0_rd,
  input  logic        req0_wr,
  input  logic [31:0] req0_lba,
  output logic        req0_busy,
  output logic        req0_done,
  output logic        req0_err,
  output logic        req0_buff_wr,
  input  logic [7:0]  req0_buff_din,
  output logic [8:0]  req0_buff_addr,
  output logic [7:0]  req0_buff_dout,
  input  logic        req1_rd,
  input  logic        req1_wr,
  input  logic [31:0] req1_lba,
  output logic        req1_busy,
  output logic        req1_done,
  output logic        req1_err,
  output logic        req1_buff_wr,
  input  logic [7:0]  req1_buff_din,
  output logic [8:0]  req1_buff_addr,
  output logic [7:0]  req1_buff_dout,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_lba,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  localparam logic [31:0] TIMER_LAST = 32'(ACK_TIMEOUT - 1);

  logic [1:0]       strobe_rd, strobe_wr, busy, pending, dir, clear_pending;
  logic [1:0][31:0] strobe_lba, lba;

  state_t      state_reg, state_next;
  logic [1:0]  grant_reg, grant_next;
  logic [1:0]  done_reg, done_next;
  logic [1:0]  err_reg, err_next;
  logic        sd_rd_reg, sd_rd_next;
  logic        sd_wr_reg, sd_wr_next;
  logic [31:0] sd_lba_reg, sd_lba_next;
  logic [31:0] timer_reg, timer_next;
  logic        last_served_reg, last_served_next;
  logic        pick;

  assign strobe_rd  = {req1_rd, req0_rd};
  assign strobe_wr  = {req1_wr, req0_wr};
  assign strobe_lba = {req1_lba, req0_lba};
  assign busy       = pending | grant_reg;

  // Per-requester capture: a strobe is taken only while the requester is idle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic        pend_reg;
      logic        dir_reg;
      logic [31:0] lba_reg;

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          pend_reg <= 1'b0;
          dir_reg  <= 1'b0;
          lba_reg  <= '0;
        end else if (clear_pending[gi]) begin
          pend_reg <= 1'b0;
        end else if (!busy[gi] && (strobe_rd[gi] || strobe_wr[gi])) begin
          pend_reg <= 1'b1;
          dir_reg  <= !strobe_rd[gi];
          lba_reg  <= strobe_lba[gi];
        end
      end

      assign pending[gi] = pend_reg;
      assign dir[gi]     = dir_reg;
      assign lba[gi]     = lba_reg;
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_reg       <= 2'b00;
      done_reg        <= 2'b00;
      err_reg         <= 2'b00;
      sd_rd_reg       <= 1'b0;
      sd_wr_reg       <= 1'b0;
      sd_lba_reg      <= '0;
      timer_reg       <= '0;
      last_served_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      sd_rd_reg       <= sd_rd_next;
      sd_wr_reg       <= sd_wr_next;
      sd_lba_reg      <= sd_lba_next;
      timer_reg       <= timer_next;
      last_served_reg <= last_served_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    done_next        = 2'b00;
    err_next         = 2'b00;
    sd_rd_next       = sd_rd_reg;
    sd_wr_next       = sd_wr_reg;
    sd_lba_next      = sd_lba_reg;
    timer_next       = timer_reg;
    last_served_next = last_served_reg;
    clear_pending    = 2'b00;
    pick             = 1'b0;

    case (state_reg)
      IDLE: begin
        // A still-high sd_ack means a transfer from before reset is draining.
        if (!sd_ack && (pending != 2'b00)) begin
          pick        = (pending == 2'b11) ? !last_served_reg : pending[1];
          grant_next  = pick ? 2'b10 : 2'b01;
          sd_lba_next = lba[pick];
          sd_rd_next  = !dir[pick];
          sd_wr_next  = dir[pick];
          timer_next  = '0;
          state_next  = REQ;
        end
      end
      REQ: begin
        if (sd_ack) begin
          sd_rd_next = 1'b0;
          sd_wr_next = 1'b0;
          state_next = XFER;
        end else if (timer_reg == TIMER_LAST) begin
          sd_rd_next       = 1'b0;
          sd_wr_next       = 1'b0;
          done_next        = grant_reg;
          err_next         = grant_reg;
          clear_pending    = grant_reg;
          grant_next       = 2'b00;
          last_served_next = grant_reg[1];
          state_next       = IDLE;
        end else if (timer_reg != '1) begin
          timer_next = timer_reg + 32'd1;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          done_next        = grant_reg;
          clear_pending    = grant_reg;
          grant_next       = 2'b00;
          last_served_next = grant_reg[1];
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sd_buff_din = 8'h00;
    if (grant_reg[0]) begin
      sd_buff_din = req0_buff_din;
    end else if (grant_reg[1]) begin
      sd_buff_din = req1_buff_din;
    end
  end

  assign req0_buff_wr   = sd_buff_wr & grant_reg[0];
  assign req1_buff_wr   = sd_buff_wr & grant_reg[1];
  assign req0_buff_addr = sd_buff_addr;
  assign req1_buff_addr = sd_buff_addr;
  assign req0_buff_dout = sd_buff_dout;
  assign req1_buff_dout = sd_buff_dout;

  assign req0_busy = busy[0];
  assign req1_busy = busy[1];
  assign req0_done = done_reg[0];
  assign req1_done = done_reg[1];
  assign req0_err  = err_reg[0];
  assign req1_err  = err_reg[1];
  assign sd_rd     = sd_rd_reg;
  assign sd_wr     = sd_wr_reg;
  assign sd_lba    = sd_lba_reg;
  assign grant     = grant_reg;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: transaction tables, directed corner sequences and
// random traffic, all checked every cycle against a transaction-level model.
module tb_sd_req_arbiter;
  localparam int T = 16;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        req0_rd = 1'b0, req0_wr = 1'b0, req1_rd = 1'b0, req1_wr = 1'b0;
  logic [31:0] req0_lba = '0, req1_lba = '0;
  logic [7:0]  req0_buff_din = '0, req1_buff_din = '0;
  logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [7:0]  sd_buff_dout = '0;
  logic        req0_busy, req0_done, req0_err, req0_buff_wr;
  logic        req1_busy, req1_done, req1_err, req1_buff_wr;
  logic [8:0]  req0_buff_addr, req1_buff_addr;
  logic [7:0]  req0_buff_dout, req1_buff_dout, sd_buff_din;
  logic        sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic [1:0]  grant;

  always #5 clk_sys = ~clk_sys;

  sd_req_arbiter #(.ACK_TIMEOUT(T)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req0_rd(req0_rd), .req0_wr(req0_wr), .req0_lba(req0_lba), .req0_busy(req0_busy),
    .req0_done(req0_done), .req0_err(req0_err), .req0_buff_wr(req0_buff_wr),
    .req0_buff_din(req0_buff_din), .req0_buff_addr(req0_buff_addr), .req0_buff_dout(req0_buff_dout),
    .req1_rd(req1_rd), .req1_wr(req1_wr), .req1_lba(req1_lba), .req1_busy(req1_busy),
    .req1_done(req1_done), .req1_err(req1_err), .req1_buff_wr(req1_buff_wr),
    .req1_buff_din(req1_buff_din), .req1_buff_addr(req1_buff_addr), .req1_buff_dout(req1_buff_dout),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .grant(grant)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pending requests per client, and the request in service
  // with its cycles waited and whether it has been acknowledged.
  bit          m_pend [2];
  bit          m_dir  [2];
  logic [31:0] m_lba  [2];
  bit          m_done [2];
  bit          m_err  [2];
  int          m_cur = -1;
  int          m_last = 1;
  int          m_wait = 0;
  bit          m_acked = 1'b0, m_line = 1'b0, m_cdir = 1'b0;
  logic [31:0] m_sdlba = '0;
  bit          chk_en = 1'b0;

  task automatic model_step();
    bit          busy_pre [2];
    bit          rd_s [2];
    bit          wr_s [2];
    logic [31:0] lba_s [2];
    rd_s[0] = req0_rd; wr_s[0] = req0_wr; lba_s[0] = req0_lba;
    rd_s[1] = req1_rd; wr_s[1] = req1_wr; lba_s[1] = req1_lba;
    for (int n = 0; n < 2; n++) begin
      busy_pre[n] = m_pend[n] || (m_cur == n);
      m_done[n] = 1'b0;
      m_err[n] = 1'b0;
    end
    if (reset) begin
      m_pend[0] = 1'b0; m_pend[1] = 1'b0;
      m_cur = -1; m_last = 1; m_line = 1'b0; m_sdlba = '0;
    end else begin
      if (m_cur >= 0) begin
        if (!m_acked) begin
          if (sd_ack) begin
            m_acked = 1'b1;
            m_line = 1'b0;
          end else begin
            m_wait++;
            if (m_wait == T) begin
              m_line = 1'b0;
              m_done[m_cur] = 1'b1;
              m_err[m_cur] = 1'b1;
              m_pend[m_cur] = 1'b0;
              m_last = m_cur;
              m_cur = -1;
            end
          end
        end else if (!sd_ack) begin
          m_done[m_cur] = 1'b1;
          m_pend[m_cur] = 1'b0;
          m_last = m_cur;
          m_cur = -1;
        end
      end else if (!sd_ack && (m_pend[0] || m_pend[1])) begin
        if (m_pend[0] && m_pend[1]) m_cur = 1 - m_last;
        else m_cur = m_pend[0] ? 0 : 1;
        m_acked = 1'b0; m_wait = 0; m_line = 1'b1;
        m_cdir = m_dir[m_cur];
        m_sdlba = m_lba[m_cur];
      end
      for (int n = 0; n < 2; n++) begin
        if (!busy_pre[n] && (rd_s[n] || wr_s[n])) begin
          m_pend[n] = 1'b1;
          m_lba[n] = lba_s[n];
          m_dir[n] = !rd_s[n];
        end
      end
    end
  endtask

  task automatic model_compare();
    logic [1:0] eg;
    logic [7:0] ed;
    eg = (m_cur == 0) ? 2'b01 : (m_cur == 1) ? 2'b10 : 2'b00;
    ed = eg[0] ? req0_buff_din : (eg[1] ? req1_buff_din : 8'h00);
    check("m_grant", grant, eg);
    check("m_sd_rd", sd_rd, m_line && !m_cdir);
    check("m_sd_wr", sd_wr, m_line && m_cdir);
    check("m_sd_lba", sd_lba, m_sdlba);
    check("m_busy0", req0_busy, m_pend[0] || m_cur == 0);
    check("m_busy1", req1_busy, m_pend[1] || m_cur == 1);
    check("m_done0", req0_done, m_done[0]);
    check("m_done1", req1_done, m_done[1]);
    check("m_err0", req0_err, m_err[0]);
    check("m_err1", req1_err, m_err[1]);
    check("m_buff_din", sd_buff_din, ed);
    check("m_buff_wr0", req0_buff_wr, sd_buff_wr && eg[0]);
    check("m_buff_wr1", req1_buff_wr, sd_buff_wr && eg[1]);
    check("m_buff_addr", {req1_buff_addr, req0_buff_addr}, {sd_buff_addr, sd_buff_addr});
    check("m_buff_dout", {req1_buff_dout, req0_buff_dout}, {sd_buff_dout, sd_buff_dout});
  endtask

  initial forever begin
    @(posedge clk_sys);
    model_step();
  end

  initial forever begin
    @(negedge clk_sys);
    if (chk_en) model_compare();
  end

  // Records every new sector request presented to user_io.
  typedef struct { logic [1:0] g; bit w; logic [31:0] l; } svc_t;
  svc_t svc_q [$];
  bit   prev_req = 1'b0;

  initial forever begin
    svc_t s;
    @(negedge clk_sys);
    if ((sd_rd || sd_wr) && !prev_req) begin
      s.g = grant; s.w = sd_wr; s.l = sd_lba;
      svc_q.push_back(s);
    end
    prev_req = sd_rd || sd_wr;
  end

  // Automatic IO controller: random ack delay and length, sometimes no ack.
  bit auto_ack = 1'b0;

  initial forever begin
    int d;
    @(negedge clk_sys);
    if (auto_ack && (sd_rd || sd_wr)) begin
      d = $urandom_range(0, 5);
      if (d == 5) begin
        for (int k = 0; k < T + 4 && (sd_rd || sd_wr); k++) @(negedge clk_sys);
      end else begin
        repeat (d) @(negedge clk_sys);
        #1 sd_ack = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk_sys);
        #1 sd_ack = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic strobe2(input bit rd0, input bit wr0, input logic [31:0] l0,
                         input bit rd1, input bit wr1, input logic [31:0] l1);
    @(posedge clk_sys); #1;
    req0_rd = rd0; req0_wr = wr0; req0_lba = l0;
    req1_rd = rd1; req1_wr = wr1; req1_lba = l1;
    @(posedge clk_sys); #1;
    req0_rd = 1'b0; req0_wr = 1'b0; req1_rd = 1'b0; req1_wr = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while ((req0_busy || req1_busy || sd_ack) && k < max_cyc);
    check("idle_reached", {req0_busy, req1_busy, sd_ack}, 3'b000);
  endtask

  task automatic wait_req(input int max_cyc);
    int k;
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (!(sd_rd || sd_wr) && k < max_cyc);
    check("req_seen", sd_rd || sd_wr, 1'b1);
  endtask

  typedef struct {
    bit rd0; bit wr0; logic [31:0] l0;
    bit rd1; bit wr1; logic [31:0] l1;
    int nsvc;
    logic [1:0] ga; bit wa; logic [31:0] la;
    logic [1:0] gb; bit wb; logic [31:0] lb;
  } txn_vec_t;

  typedef struct {
    logic [7:0] din0; logic [7:0] din1; bit bwr;
    logic [7:0] exp_din; bit exp_w0; bit exp_w1;
  } route_vec_t;

  txn_vec_t   tv [6];
  route_vec_t rv [4];

  initial begin
    int rd_cnt, done_cnt, err_cnt, done_at, err_at;

    tv[0] = '{0, 1, 32'd5,     1, 0, 32'd9,     2, 2'b01, 1, 32'd5,     2'b10, 0, 32'd9};
    tv[1] = '{1, 0, 32'h1234,  0, 0, 32'd0,     1, 2'b01, 0, 32'h1234,  2'b00, 0, 32'd0};
    tv[2] = '{1, 0, 32'h77,    0, 1, 32'h88,    2, 2'b10, 1, 32'h88,    2'b01, 0, 32'h77};
    tv[3] = '{0, 0, 32'd0,     1, 1, 32'hABC,   1, 2'b10, 0, 32'hABC,   2'b00, 0, 32'd0};
    tv[4] = '{1, 1, 32'd3,     0, 1, 32'd4,     2, 2'b01, 0, 32'd3,     2'b10, 1, 32'd4};
    tv[5] = '{0, 0, 32'd0,     0, 0, 32'd0,     0, 2'b00, 0, 32'd0,     2'b00, 0, 32'd0};

    rv[0] = '{8'h3C, 8'hA5, 1, 8'hA5, 0, 1};
    rv[1] = '{8'h3C, 8'hA5, 0, 8'hA5, 0, 0};
    rv[2] = '{8'hFF, 8'h00, 1, 8'h00, 0, 1};
    rv[3] = '{8'h11, 8'h22, 1, 8'h22, 0, 1};

    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk_sys);
    check("rst_grant", grant, 2'b00);
    check("rst_sd_rdwr", {sd_rd, sd_wr}, 2'b00);
    check("rst_sd_lba", sd_lba, 32'd0);
    check("rst_busy", {req1_busy, req0_busy}, 2'b00);
    check("rst_done_err", {req1_done, req0_done, req1_err, req0_err}, 4'b0000);

    // Transaction table: order, direction and address of each service.
    auto_ack = 1'b1;
    for (int r = 0; r < 6; r++) begin
      svc_q.delete();
      strobe2(tv[r].rd0, tv[r].wr0, tv[r].l0, tv[r].rd1, tv[r].wr1, tv[r].l1);
      wait_idle(200);
      check($sformatf("tv%0d_nsvc", r), svc_q.size(), tv[r].nsvc);
      if (svc_q.size() >= 1 && tv[r].nsvc >= 1)
        check($sformatf("tv%0d_first", r), {svc_q[0].g, 1'(svc_q[0].w), svc_q[0].l},
              {tv[r].ga, 1'(tv[r].wa), tv[r].la});
      if (svc_q.size() >= 2 && tv[r].nsvc >= 2)
        check($sformatf("tv%0d_second", r), {svc_q[1].g, 1'(svc_q[1].w), svc_q[1].l},
              {tv[r].gb, 1'(tv[r].wb), tv[r].lb});
    end
    auto_ack = 1'b0;
    wait_idle(50);

    // Single read with an ignored second strobe while busy.
    svc_q.delete();
    strobe2(1, 0, 32'h0000_1234, 0, 0, 32'd0);
    rd_cnt = 0; done_cnt = 0; err_cnt = 0; done_at = -1;
    for (int i = 0; i < 560; i++) begin
      @(negedge clk_sys);
      if (i == 0) check("rd_busy_after_strobe", req0_busy, 1'b1);
      if (i == 1) check("rd_grant_lba", {grant, sd_rd, sd_lba}, {2'b01, 1'b1, 32'h1234});
      rd_cnt += int'(sd_rd);
      err_cnt += int'(req0_err);
      if (req0_done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      #1;
      if (i == 3) sd_ack = 1'b1;
      if (i == 10) begin req0_rd = 1'b1; req0_lba = 32'h0000_DEAD; end
      if (i == 11) req0_rd = 1'b0;
      if (i == 523) sd_ack = 1'b0;
    end
    check("rd_sd_rd_cycles", rd_cnt, 3);
    check("rd_done_count", done_cnt, 1);
    check("rd_done_cycle", done_at, 524);
    check("rd_err_count", err_cnt, 0);
    check("rd_ignored_strobe_svc", svc_q.size(), 1);
    check("rd_lba_kept", sd_lba, 32'h1234);
    check("rd_busy_end", req0_busy, 1'b0);

    // Watchdog abort for requester 1.
    strobe2(0, 0, 32'd0, 1, 0, 32'h42);
    rd_cnt = 0; done_cnt = 0; done_at = -1; err_at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_sys);
      rd_cnt += int'(sd_rd);
      if (req1_done) begin done_cnt++; done_at = i; end
      if (req1_err) err_at = i;
    end
    check("to_sd_rd_cycles", rd_cnt, T);
    check("to_done_count", done_cnt, 1);
    check("to_done_cycle", done_at, T + 1);
    check("to_err_cycle", err_at, T + 1);
    check("to_busy_end", req1_busy, 1'b0);

    // Buffer routing during a requester-1 write.
    strobe2(0, 0, 32'd0, 0, 1, 32'h100);
    wait_req(8);
    check("br_grant_wr", {grant, sd_wr}, {2'b10, 1'b1});
    #1 sd_ack = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk_sys);
      #1;
      req0_buff_din = rv[r].din0; req1_buff_din = rv[r].din1; sd_buff_wr = rv[r].bwr;
      #2;
      check($sformatf("rv%0d_din", r), sd_buff_din, rv[r].exp_din);
      check($sformatf("rv%0d_wr", r), {req0_buff_wr, req1_buff_wr}, {rv[r].exp_w0, rv[r].exp_w1});
    end
    @(negedge clk_sys);
    #1 sd_ack = 1'b0; sd_buff_wr = 1'b0;
    wait_idle(10);
    #1 req0_buff_din = 8'h3C; req1_buff_din = 8'hA5;
    #2 check("br_idle_din", sd_buff_din, 8'h00);

    // Reset during XFER while sd_ack stays high.
    strobe2(1, 0, 32'h55, 0, 0, 32'd0);
    wait_req(8);
    #1 sd_ack = 1'b1;
    @(posedge clk_sys); #1 reset = 1'b1;
    @(posedge clk_sys); #1 reset = 1'b0;
    @(negedge clk_sys);
    check("rx_reset_outs", {grant, sd_rd, sd_wr, req0_busy, req0_done}, 6'b0);
    check("rx_reset_lba", sd_lba, 32'd0);
    strobe2(1, 0, 32'h66, 0, 0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      check("rx_no_grant_while_ack", grant, 2'b00);
    end
    #1 sd_ack = 1'b0;
    @(negedge clk_sys);
    check("rx_grant_after_ack_low", {grant, sd_rd, sd_lba}, {2'b01, 1'b1, 32'h66});
    #1 sd_ack = 1'b1;
    repeat (2) @(negedge clk_sys);
    #1 sd_ack = 1'b0;
    wait_idle(10);

    // Random traffic against the model.
    auto_ack = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_sys); #1;
      req0_rd = ($urandom_range(0, 7) == 0); req0_wr = ($urandom_range(0, 7) == 0);
      req1_rd = ($urandom_range(0, 7) == 0); req1_wr = ($urandom_range(0, 7) == 0);
      req0_lba = $urandom; req1_lba = $urandom;
      req0_buff_din = 8'($urandom); req1_buff_din = 8'($urandom);
      sd_buff_wr = 1'($urandom); sd_buff_addr = 9'($urandom); sd_buff_dout = 8'($urandom);
    end
    @(posedge clk_sys); #1;
    req0_rd = 1'b0; req0_wr = 1'b0; req1_rd = 1'b0; req1_wr = 1'b0;
    wait_idle(300);
    auto_ack = 1'b0;
    repeat (4) @(negedge clk_sys);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_req_arbiter.md
# sd_req_arbiter

Two-requester arbiter for the user_io SD sector interface (sd_rd/sd_wr/sd_lba/sd_ack plus the 512-byte buffer port). It sits between user_io/sd_card and two clients: the MSX SD-card emulation path (requester 0) and a disk-image/ROM loader (requester 1). It serialises their sector requests with round-robin fairness and routes the buffer traffic to the granted client. A watchdog releases the bus if the IO controller never acknowledges a request.

## Interface
- ACK_TIMEOUT, 4_000_000: clk_sys cycles waited in REQ for sd_ack before aborting.
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- reqN_rd / reqN_wr (N=0,1)  in  1 each  one-cycle read/write strobes; accepted only while reqN_busy=0.
- reqN_lba  in  32  sector address; sampled on the strobe cycle.
- reqN_busy  out  1  request pending or in service.
- reqN_done  out  1  one-cycle pulse at end of service.
- reqN_err  out  1  one-cycle pulse coincident with done on timeout abort.
- reqN_buff_wr  out  1  sd_buff_wr gated by grant.
- reqN_buff_din  in  8  requester write data to the IO controller.
- sd_rd, sd_wr  out  1 each  to user_io.
- sd_lba  out  32  to user_io.
- sd_ack  in  1  from user_io.
- sd_buff_addr  in  9, sd_buff_dout  in  8: broadcast to both requesters unchanged.
- sd_buff_wr  in  1  byte strobe from the IO controller.
- sd_buff_din  out  8  muxed requester data.
- grant  out  2  one-hot, 00 when idle.

## Operation
- Per requester: pending flag, direction bit and 32-bit LBA register. A strobe with busy=0 sets pending, captures lba, and sets dir (rd=0, wr=1). If rd and wr strobe together, rd wins. Strobes while busy=1 are ignored.
- busy = pending OR granted.
- FSM states: IDLE, REQ, XFER.
  - IDLE: no grant while sd_ack=1 (covers reset mid-transfer). If exactly one requester is pending, grant it. If both are pending, grant the one not equal to the last_served pointer. On grant: load sd_lba, assert sd_rd or sd_wr per dir, clear the timer, go to REQ.
  - REQ: if sd_ack=1, drop sd_rd/sd_wr and go to XFER. Otherwise the timer increments. When the timer reaches ACK_TIMEOUT-1: drop sd_rd/sd_wr, pulse done and err, clear pending and grant, update last_served, go to IDLE.
  - XFER: when sd_ack=0, pulse done, clear pending and grant, update last_served, go to IDLE.
- Buffer routing (combinational):
  - reqN_buff_wr = sd_buff_wr & grant[N].
  - sd_buff_din = reqN_buff_din of the granted requester, 8'h00 when grant=00.
- last_served resets to 1, so requester 0 wins the first tie.
- Timer is 32 bits wide, saturating; it is only live in REQ.

## Timing
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, grant=00, busy=0, done=0, err=0, pending=0, state=IDLE. Reset aborts any service without a done pulse.
- Strobe sampled at edge T: busy=1 after T. With the bus free, sd_rd/sd_wr, sd_lba and grant are valid after edge T+1.
- sd_ack sampled high at edge E: sd_rd/sd_wr low after E.
- sd_ack sampled low in XFER at edge F: done=1 for the cycle after F, busy=0 after F. A waiting requester is granted at F+1.
- Minimum back-to-back gap: one idle cycle between done and the next sd_rd/sd_wr.
- Timeout: abort at exactly ACK_TIMEOUT cycles after entering REQ.
- A requester may strobe again on the cycle done is high; busy is already 0.

## Test plan
- Single read: req0_rd with lba=0x00001234; sd_ack high 3 cycles later for 520 cycles -> sd_rd high for exactly 3 cycles with sd_lba=0x1234, grant=01, req0_done one pulse, req0_err=0.
- Simultaneous strobes: req0_wr (lba=5) and req1_rd (lba=9) on the same edge -> requester 0 served first with sd_wr; requester 1 served next with sd_rd and lba=9. Repeat the tie -> requester 1 is served first.
- Buffer routing: during a requester-1 write with req1_buff_din=0xA5 and req0_buff_din=0x3C -> sd_buff_din=0xA5. sd_buff_wr pulses appear only on req1_buff_wr.
- Timeout: ACK_TIMEOUT=16, req1_rd, sd_ack held 0 -> sd_rd drops after 16 cycles in REQ, req1_done and req1_err pulse together, busy=0.
- Ignored strobe: req0_rd while req0_busy=1 with a different lba -> no second transfer; sd_lba keeps the first value.
- Reset mid-XFER with sd_ack still high -> outputs go to their reset values. A new req0_rd is not granted until sd_ack falls, then sd_rd asserts on the following cycle.
